// File: rtl/useq_ctrl.sv
// ============================================================================
// Module   : useq_ctrl
// Function : Microprogram sequencer with a writable store that steps a
//            micro-PC and drives the datapath control word each cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module useq_ctrl #(
    parameter int AW = 4,
    parameter int UW = 18 + AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] start_adr,
    input  logic          abort,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_adr,
    input  logic [UW-1:0] prog_data,
    input  logic          pout,
    input  logic          osr,
    input  logic          osl,
    input  logic [3:0]    rout,
    output logic [3:0]    S,
    output logic          M,
    output logic          Pin,
    output logic          A,
    output logic [3:0]    v,
    output logic [2:0]    adr,
    output logic          wr,
    output logic [AW-1:0] upc,
    output logic          busy,
    output logic          done
);

    localparam int c_DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_upc;
    logic [UW-1:0] r_mir;
    logic [UW-1:0] r_mem [0:c_DEPTH-1];

    logic [2:0]    w_cond;
    logic [AW-1:0] w_next;
    logic [AW-1:0] w_upc_inc;
    logic          w_take;
    logic [AW-1:0] w_target;

    assign w_cond    = r_mir[17:15];
    assign w_next    = r_mir[UW-1:18];
    assign w_upc_inc = r_upc + AW'(1);

    always_comb begin
        w_take = 1'b0;
        case (w_cond)
            3'b001:  w_take = 1'b1;
            3'b010:  w_take = pout;
            3'b011:  w_take = ~pout;
            3'b100:  w_take = (rout == 4'd0);
            3'b101:  w_take = osr;
            3'b110:  w_take = osl;
            default: w_take = 1'b0;
        endcase
    end

    assign w_target = w_take ? w_next : w_upc_inc;

    // The store has no reset so a program survives a reset pulse.
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && prog_we && !start) begin
            r_mem[prog_adr] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_upc   <= '0;
            r_mir   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_upc   <= start_adr;
                        r_mir   <= r_mem[start_adr];
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_mir   <= '0;
                        r_state <= ST_IDLE;
                    end else if (w_cond == 3'b111) begin
                        r_mir   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_upc <= w_target;
                        r_mir <= r_mem[w_target];
                    end
                end
                ST_DONE: begin
                    r_mir   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_mir   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // MIR is cleared whenever the sequencer leaves RUN, so the control
    // outputs come straight from it and read 0 outside RUN.
    assign wr   = r_mir[0];
    assign adr  = r_mir[3:1];
    assign v    = r_mir[7:4];
    assign A    = r_mir[8];
    assign Pin  = r_mir[9];
    assign M    = r_mir[10];
    assign S    = r_mir[14:11];
    assign upc  = r_upc;
    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_useq_ctrl.sv
// ============================================================================
// Module   : tb_useq_ctrl
// Function : Directed self-checking bench for the microprogram sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_useq_ctrl;

    localparam int AW = 4;
    localparam int UW = 18 + AW;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_adr;
    logic          abort;
    logic          prog_we;
    logic [AW-1:0] prog_adr;
    logic [UW-1:0] prog_data;
    logic          pout;
    logic          osr;
    logic          osl;
    logic [3:0]    rout;
    logic [3:0]    S;
    logic          M;
    logic          Pin;
    logic          A;
    logic [3:0]    v;
    logic [2:0]    adr;
    logic          wr;
    logic [AW-1:0] upc;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;

    useq_ctrl #(.AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .start_adr(start_adr),
        .abort(abort), .prog_we(prog_we), .prog_adr(prog_adr),
        .prog_data(prog_data), .pout(pout), .osr(osr), .osl(osl),
        .rout(rout), .S(S), .M(M), .Pin(Pin), .A(A), .v(v), .adr(adr),
        .wr(wr), .upc(upc), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [14:0] w_ctl;
    assign w_ctl = {S, M, Pin, A, v, adr, wr};

    function automatic logic [UW-1:0] mk(input logic [AW-1:0] nxt, input logic [2:0] cond,
                                         input logic [3:0] s_f, input logic m_f,
                                         input logic pin_f, input logic a_f,
                                         input logic [3:0] v_f, input logic [2:0] adr_f,
                                         input logic wr_f);
        return {nxt, cond, s_f, m_f, pin_f, a_f, v_f, adr_f, wr_f};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic prog(input logic [AW-1:0] a, input logic [UW-1:0] d);
        prog_we = 1'b1; prog_adr = a; prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic do_start(input logic [AW-1:0] a);
        start = 1'b1; start_adr = a;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Check the word active in this cycle, then advance one cycle.
    task automatic step(input string tag, input logic [AW-1:0] eu, input logic [UW-1:0] ew);
        check({tag, ".upc"}, 32'(upc), 32'(eu));
        check({tag, ".busy"}, 32'(busy), 32'd1);
        check({tag, ".ctl"}, 32'(w_ctl), 32'(ew[14:0]));
        @(negedge clk);
    endtask

    task automatic fin(input string tag, input logic [AW-1:0] eu);
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".done_busy"}, 32'(busy), 32'd0);
        check({tag, ".done_ctl"}, 32'(w_ctl), 32'd0);
        check({tag, ".done_upc"}, 32'(upc), 32'(eu));
        @(negedge clk);
        check({tag, ".idle_done"}, 32'(done), 32'd0);
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check({tag, ".idle_ctl"}, 32'(w_ctl), 32'd0);
    endtask

    logic [UW-1:0] W0, W1, W2, W4, W5, W6, W8, W9, W10, W11, W12, W13, W14, W15;

    initial begin
        W0  = mk(4'd0,  3'b000, 4'h3, 1'b1, 1'b0, 1'b1, 4'h2, 3'd1, 1'b1);
        W1  = mk(4'd0,  3'b000, 4'hA, 1'b0, 1'b1, 1'b0, 4'h8, 3'd6, 1'b0);
        W2  = mk(4'd0,  3'b111, 4'h5, 1'b1, 1'b1, 1'b1, 4'hF, 3'd7, 1'b1);
        W4  = mk(4'd12, 3'b100, 4'h7, 1'b1, 1'b0, 1'b0, 4'h4, 3'd2, 1'b0);
        W5  = mk(4'd9,  3'b010, 4'b1001, 1'b0, 1'b0, 1'b0, 4'b0001, 3'd3, 1'b1);
        W6  = mk(4'd0,  3'b111, 4'h6, 1'b0, 1'b0, 1'b1, 4'h6, 3'd6, 1'b0);
        W8  = mk(4'd10, 3'b001, 4'h8, 1'b0, 1'b1, 1'b1, 4'h1, 3'd0, 1'b1);
        W9  = mk(4'd0,  3'b111, 4'h9, 1'b1, 1'b0, 1'b0, 4'h9, 3'd1, 1'b0);
        W10 = mk(4'd13, 3'b011, 4'hB, 1'b1, 1'b1, 1'b0, 4'h3, 3'd5, 1'b0);
        W11 = mk(4'd14, 3'b110, 4'hD, 1'b0, 1'b0, 1'b1, 4'hC, 3'd4, 1'b1);
        W12 = mk(4'd0,  3'b111, 4'hC, 1'b0, 1'b1, 1'b0, 4'hA, 3'd2, 1'b1);
        W13 = mk(4'd11, 3'b101, 4'hE, 1'b1, 1'b0, 1'b1, 4'h5, 3'd3, 1'b0);
        W14 = mk(4'd0,  3'b111, 4'h2, 1'b0, 1'b1, 1'b1, 4'h7, 3'd5, 1'b1);
        W15 = mk(4'd7,  3'b000, 4'hF, 1'b1, 1'b1, 1'b0, 4'hE, 3'd4, 1'b0);

        reset = 1'b0; start = 1'b0; start_adr = '0; abort = 1'b0;
        prog_we = 1'b0; prog_adr = '0; prog_data = '0;
        pout = 1'b0; osr = 1'b0; osl = 1'b0; rout = 4'h1;

        #12;
        check("rst.ctl",  32'(w_ctl), 32'd0);
        check("rst.upc",  32'(upc), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        prog(4'd0, W0);  prog(4'd1, W1);  prog(4'd2, W2);  prog(4'd4, W4);
        prog(4'd5, W5);  prog(4'd6, W6);  prog(4'd8, W8);  prog(4'd9, W9);
        prog(4'd10, W10); prog(4'd11, W11); prog(4'd12, W12); prog(4'd13, W13);
        prog(4'd14, W14); prog(4'd15, W15);
        check("idle.ctl", 32'(w_ctl), 32'd0);

        // Straight-line program 0..2
        do_start(4'd0);
        step("seq0", 4'd0, W0); step("seq1", 4'd1, W1); step("seq2", 4'd2, W2);
        fin("seq", 4'd2);

        // cond 010 taken / not taken
        pout = 1'b1;
        do_start(4'd5);
        step("pt5", 4'd5, W5); step("pt9", 4'd9, W9); fin("pt", 4'd9);
        pout = 1'b0;
        do_start(4'd5);
        step("pn5", 4'd5, W5); step("pn6", 4'd6, W6); fin("pn", 4'd6);

        // cond 100 zero / nonzero
        rout = 4'b0000;
        do_start(4'd4);
        step("z4", 4'd4, W4); step("z12", 4'd12, W12); fin("z", 4'd12);
        rout = 4'b0100;
        do_start(4'd4);
        step("nz4", 4'd4, W4); step("nz5", 4'd5, W5); step("nz6", 4'd6, W6); fin("nz", 4'd6);

        // Chain of 001, 011, 101, 110; a start during RUN is ignored
        pout = 1'b0; osr = 1'b1; osl = 1'b1;
        do_start(4'd8);
        start = 1'b1; start_adr = 4'd0;
        step("ch8", 4'd8, W8);
        start = 1'b0;
        step("ch10", 4'd10, W10); step("ch13", 4'd13, W13);
        step("ch11", 4'd11, W11); step("ch14", 4'd14, W14); fin("ch", 4'd14);
        osr = 1'b0; osl = 1'b0;

        // Wrap 15 -> 0
        do_start(4'd15);
        step("w15", 4'd15, W15); step("w0", 4'd0, W0); step("w1", 4'd1, W1);
        step("w2", 4'd2, W2); fin("w", 4'd2);

        // Abort on second RUN cycle
        do_start(4'd0);
        step("ab0", 4'd0, W0);
        abort = 1'b1;
        check("ab.cur_ctl", 32'(w_ctl), 32'(W1[14:0]));
        @(negedge clk);
        abort = 1'b0;
        check("ab.busy", 32'(busy), 32'd0);
        check("ab.wr",   32'(wr), 32'd0);
        check("ab.v",    32'(v), 32'd0);
        check("ab.done", 32'(done), 32'd0);
        @(negedge clk);
        check("ab.done2", 32'(done), 32'd0);

        // Abort together with start in IDLE
        abort = 1'b1; start = 1'b1; start_adr = 4'd0;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abst.busy", 32'(busy), 32'd0);
        check("abst.ctl",  32'(w_ctl), 32'd0);

        // Asynchronous reset mid-run, then re-run
        do_start(4'd0);
        step("rr0", 4'd0, W0);
        #2 reset = 1'b0;
        #1;
        check("arst.ctl",  32'(w_ctl), 32'd0);
        check("arst.busy", 32'(busy), 32'd0);
        check("arst.upc",  32'(upc), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        do_start(4'd0);
        step("ra0", 4'd0, W0); step("ra1", 4'd1, W1); step("ra2", 4'd2, W2);
        fin("ra", 4'd2);

        // Write attempt during RUN must not alter the store
        do_start(4'd0);
        prog_we = 1'b1; prog_adr = 4'd1; prog_data = mk(4'd3, 3'b001, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0);
        step("pw0", 4'd0, W0);
        step("pw1", 4'd1, W1);
        prog_we = 1'b0;
        step("pw2", 4'd2, W2); fin("pw", 4'd2);
        do_start(4'd0);
        step("pr0", 4'd0, W0); step("pr1", 4'd1, W1); step("pr2", 4'd2, W2);
        fin("pr", 4'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/useq_ctrl.md
Name: useq_ctrl

Overview:
- Microprogram sequencer that sits directly upstream of the register/ALU datapath in the CU.
- Holds a writable microcode store and steps a micro-PC through it.
- Drives the datapath control word every cycle: S, M, Pin, A, v, adr, wr.
- Branches on the datapath's returned flags: carry Pout, shift-outs OSR/OSL, and zero of Rout.

Parameters:
- AW, 4, micro-address width; store depth = 2**AW words.
- UW, 18+AW, microword width (derived; do not override).

Ports:
- clk  in  1  clock, all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin execution at start_adr (sampled in IDLE only).
- start_adr  in  AW  entry micro-address.
- abort  in  1  force return to IDLE.
- prog_we  in  1  microcode write strobe.
- prog_adr  in  AW  microcode write address.
- prog_data  in  UW  microcode word.
- pout  in  1  datapath carry out.
- osr  in  1  datapath right-shift out bit.
- osl  in  1  datapath left-shift out bit.
- rout  in  4  datapath result bus.
- S  out  4  ALU function select.
- M  out  1  logic/arith mode.
- Pin  out  1  ALU carry in.
- A  out  1  register-A source select (1 = external data).
- v  out  4  register enables / B-shift control.
- adr  out  3  register file address.
- wr  out  1  register file write.
- upc  out  AW  current micro-PC.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on program end.

Behaviour:
- Microword layout:
  - [0] wr, [3:1] adr, [7:4] v, [8] A, [9] Pin, [10] M, [14:11] S.
  - [17:15] cond, [UW-1:18] next.
- Reset (reset=0, async): state=IDLE, upc=0, MIR=0, all outputs 0. Microcode store is NOT cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - Control outputs forced 0; busy=0; done=0.
  - prog_we=1 with start=0: mem[prog_adr] <= prog_data.
  - start=1: upc <= start_adr, MIR <= mem[start_adr], go to RUN. A prog_we in the same cycle is ignored.
- RUN:
  - Control outputs = MIR fields (registered; no combinational path from memory).
  - busy=1; each microword is active for exactly one cycle.
  - At each edge, the target is chosen from MIR.cond and the flags sampled at that edge:
    - 000: upc+1.
    - 001: next (unconditional).
    - 010: next if pout, else upc+1.
    - 011: next if !pout, else upc+1.
    - 100: next if rout==0, else upc+1.
    - 101: next if osr, else upc+1.
    - 110: next if osl, else upc+1.
    - 111: END, go to DONE; MIR <= 0.
  - Otherwise upc <= target and MIR <= mem[target].
  - upc+1 wraps modulo 2**AW (15 -> 0 for AW=4).
  - prog_we is ignored in RUN and DONE.
- DONE:
  - Outputs 0, done=1 for exactly one cycle, then IDLE.
  - upc holds the END word's address.
- abort=1 in RUN or DONE:
  - Next edge: state=IDLE, MIR=0, done=0.
  - The current word still drives its outputs during the abort cycle.
  - abort has priority over cond.
  - abort in IDLE is ignored; abort and start together in IDLE: abort wins, stay IDLE.
- start while RUN/DONE: ignored.
- Reset mid-RUN: outputs go to 0 immediately (async); the store is retained, so re-running after reset reproduces the result.
- Latency:
  - start edge -> first control word visible in the following cycle.
  - A program of N words (END included) occupies N cycles of busy, then one cycle of done.

Test Plan:
- Load words 0..2 (cond 000, 000, 111), start_adr=0 -> busy for 3 cycles, upc 0,1,2, then done=1 for 1 cycle, then outputs 0.
- Word 5 = {S=1001, M=0, v=0001, wr=1, adr=3, cond=010, next=9}, pout=1 at the edge -> upc 5->9; repeat with pout=0 -> upc 5->6.
- Word 4 cond=100, next=12: with rout=0000 -> upc 12; with rout=0100 -> upc 5.
- Word 15 cond=000 -> upc wraps to 0 and mem[0] is driven.
- abort asserted on 2nd RUN cycle -> next cycle IDLE, wr=0, v=0, no done pulse.
- Reset low mid-RUN: outputs 0 asynchronously. Release, start again -> identical control sequence (store retained).
- prog_we=1 during RUN to address 1 -> mem[1] unchanged on the next run.
